// File: rtl/pred_stream_ctrl.sv
// pred_stream_ctrl: issues a stream of samples with a 3-deep history window to a fixed-latency
// model pipeline and collects its results in a credit-guarded FIFO.
module pred_stream_ctrl #(
    parameter int LATENCY    = 36,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_elems,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      m_proceed1,
    output logic [31:0]      m_proceed2,
    output logic [31:0]      m_proceed3,
    output logic [31:0]      m_data_in,
    input  logic [31:0]      m_error,
    input  logic [31:0]      m_real_error,
    input  logic [31:0]      m_data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_error,
    output logic [31:0]      out_real_error,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic             done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t           state;
    logic [CNT_W-1:0] n_reg, issued;
    logic [31:0]      w1, w2, w3;
    logic [LATENCY:0] vsr;
    logic [AW:0]      inflight, fifo_count;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [95:0]      mem [FIFO_DEPTH];
    logic [AW+1:0]    occ;
    logic             credit, accept, push, pop;
    // Credit counts results still in the model, so a push can never meet a full FIFO
    assign occ       = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit    = occ < (AW+2)'(FIFO_DEPTH);
    assign in_ready  = state == RUN && issued < n_reg && credit;
    assign accept    = in_valid && in_ready;
    assign push      = vsr[LATENCY];
    assign out_valid = fifo_count != 0;
    assign pop       = out_valid && out_ready;
    assign {out_error, out_real_error, out_data} = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            n_reg      <= '0;
            issued     <= '0;
            w1         <= '0;
            w2         <= '0;
            w3         <= '0;
            m_data_in  <= '0;
            m_proceed1 <= '0;
            m_proceed2 <= '0;
            m_proceed3 <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state  <= num_elems != 0 ? RUN : DONE;
                    busy   <= 1'b1;
                    done   <= num_elems == 0;
                    n_reg  <= num_elems;
                    issued <= '0;
                    w1     <= '0;
                    w2     <= '0;
                    w3     <= '0;
                end
                RUN: if (issued == n_reg) state <= DRAIN;
                DRAIN: if (inflight == 0 && fifo_count == 0) begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
            if (accept) begin
                m_data_in  <= in_data;
                m_proceed1 <= w1;
                m_proceed2 <= w2;
                m_proceed3 <= w3;
                w3         <= w2;
                w2         <= w1;
                w1         <= in_data;
                issued     <= issued + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            vsr        <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            vsr        <= {vsr[LATENCY-1:0], accept};
            inflight   <= inflight + (AW+1)'(accept) - (AW+1)'(push);
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {m_error, m_real_error, m_data_out};
    end
    assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_count == (AW+1)'(FIFO_DEPTH) && !pop))
        else $error("pred_stream_ctrl: push into full result FIFO");
endmodule

// File: tb/tb_pred_stream_ctrl.sv
// tb_pred_stream_ctrl: directed vectors plus multi-cycle sequences against a delay-line model.
module tb_pred_stream_ctrl;
    localparam int LAT = 36;
    localparam int DEPTH = 64;
    logic        clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
    logic [31:0] num_elems = 0, in_data = 0;
    logic        in_ready, out_valid, busy, done;
    logic [31:0] m_proceed1, m_proceed2, m_proceed3, m_data_in;
    logic [31:0] m_error, m_real_error, m_data_out;
    logic [31:0] out_error, out_real_error, out_data;
    typedef struct {logic [31:0] d, e, r; int t;} exp_t;
    typedef struct {logic [31:0] x, p1, p2, p3;} vec_t;
    exp_t        exp_q[$];
    exp_t        m_e;
    vec_t        tv[3];
    logic [31:0] prev = 0;
    logic [31:0] pd [LAT];
    logic [31:0] pe [LAT];
    int cyc = 0, checks = 0, passes = 0, done_cnt = 0, rx_cnt = 0;

    pred_stream_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .num_elems(num_elems),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .m_proceed1(m_proceed1), .m_proceed2(m_proceed2), .m_proceed3(m_proceed3),
        .m_data_in(m_data_in), .m_error(m_error), .m_real_error(m_real_error),
        .m_data_out(m_data_out), .out_valid(out_valid), .out_ready(out_ready),
        .out_error(out_error), .out_real_error(out_real_error), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in model: error = x[n-1], real_error = x[n] - x[n-1], data_out = x[n]
    always @(posedge clk) begin
        pd[0] <= m_data_in;
        pe[0] <= m_proceed1;
        for (int k = 1; k < LAT; k++) begin
            pd[k] <= pd[k-1];
            pe[k] <= pe[k-1];
        end
    end
    assign m_data_out   = pd[LAT-1];
    assign m_error      = pe[LAT-1];
    assign m_real_error = pd[LAT-1] - pe[LAT-1];

    always @(negedge clk) begin
        #1;
        if (!rst && done) done_cnt++;
        if (!rst && out_valid && out_ready) begin
            checks++;
            rx_cnt++;
            if (exp_q.size() == 0) $display("FAIL extra_beat: got %h expected none", out_data);
            else begin
                m_e = exp_q.pop_front();
                if (out_data == m_e.d && out_error == m_e.e && out_real_error == m_e.r && (m_e.t < 0 || m_e.t == cyc))
                    passes++;
                else
                    $display("FAIL result: got %h/%h/%h @%0d expected %h/%h/%h @%0d",
                             out_data, out_error, out_real_error, cyc, m_e.d, m_e.e, m_e.r, m_e.t);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] val(input int i);
        return 32'h3f80_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    task automatic push_exp(input logic [31:0] x, input bit timed);
        exp_q.push_back('{d: x, e: prev, r: x - prev, t: timed ? cyc + LAT + 1 : -1});
        prev = x;
    endtask

    task automatic start_block(input int n);
        start = 1;
        num_elems = n;
        prev = 0;
        @(negedge clk);
        start = 0;
    endtask

    task automatic send(input logic [31:0] x, input bit timed);
        int t = 0;
        in_data = x;
        in_valid = 1;
        while (!in_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) chk("send_timeout", 1, 0);
        @(negedge clk);
        push_exp(x, timed);
    endtask

    task automatic wait_idle();
        int t = 0;
        in_valid = 0;
        while (busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("idle", busy, 0);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    task automatic run_t1();
        int d0 = done_cnt, r0 = rx_cnt;
        out_ready = 1;
        start_block(3);
        for (int i = 0; i < 3; i++) begin
            send(tv[i].x, 1);
            chk("m_data_in", m_data_in, tv[i].x);
            chk("m_proceed1", m_proceed1, tv[i].p1);
            chk("m_proceed2", m_proceed2, tv[i].p2);
            chk("m_proceed3", m_proceed3, tv[i].p3);
        end
        wait_idle();
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_beats", rx_cnt - r0, 3);
    endtask

    task automatic stream(input int n, input bit tog);
        int i = 0, stall = 0, t = 0, d0 = done_cnt, r0 = rx_cnt;
        out_ready = 0;
        start_block(n);
        while (stall < 100 && t < 2000) begin
            in_data = val(i);
            in_valid = 1;
            if (in_ready) begin
                push_exp(val(i), 0);
                i++;
                stall = 0;
            end else stall++;
            @(negedge clk);
            t++;
        end
        chk("fill_accepts", i, DEPTH);
        chk("fill_out_valid", out_valid, 1);
        chk("fill_no_beats", rx_cnt - r0, 0);
        t = 0;
        while (i < n && t < 5000) begin
            out_ready = tog ? ~out_ready : 1'b1;
            in_data = val(i);
            in_valid = 1;
            if (in_ready) begin
                push_exp(val(i), 0);
                i++;
            end
            @(negedge clk);
            t++;
        end
        out_ready = 1;
        wait_idle();
        chk("stream_beats", rx_cnt - r0, n);
        chk("stream_done", done_cnt - d0, 1);
    endtask

    initial begin
        int d0, r0, bc, ir, ov;
        tv[0] = '{32'h3fc00000, 32'h0, 32'h0, 32'h0};
        tv[1] = '{32'h3fcccccd, 32'h3fc00000, 32'h0, 32'h0};
        tv[2] = '{32'h3fa66666, 32'h3fcccccd, 32'h3fc00000, 32'h0};
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_data_in", m_data_in, 0);
        chk("rst_m_proceed1", m_proceed1, 0);
        chk("rst_m_proceed2", m_proceed2, 0);
        chk("rst_m_proceed3", m_proceed3, 0);

        run_t1();
        stream(200, 0);

        d0 = done_cnt; bc = 0; ir = 0; ov = 0;
        start = 1;
        num_elems = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 0;
            bc += int'(busy);
            ir |= int'(in_ready);
            ov |= int'(out_valid);
        end
        chk("zero_busy_cycles", bc >= 1 && bc <= 2, 1);
        chk("zero_done", done_cnt - d0, 1);
        chk("zero_in_ready", ir, 0);
        chk("zero_out_valid", ov, 0);

        d0 = done_cnt; r0 = rx_cnt; ir = 0;
        out_ready = 1;
        start_block(5);
        send(val(10), 0);
        send(val(11), 0);
        in_valid = 0;
        start = 1;
        num_elems = 9;
        @(negedge clk);
        start = 0;
        for (int i = 12; i < 15; i++) send(val(i), 0);
        in_data = val(99);
        in_valid = 1;
        repeat (10) begin
            ir |= int'(in_ready);
            @(negedge clk);
        end
        chk("restart_in_ready", ir, 0);
        wait_idle();
        chk("restart_beats", rx_cnt - r0, 5);
        chk("restart_done", done_cnt - d0, 1);

        d0 = done_cnt;
        start_block(20);
        for (int i = 0; i < 10; i++) send(val(40 + i), 0);
        in_valid = 0;
        rst = 1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_m_data_in", m_data_in, 0);
        chk("midrst_m_proceed1", m_proceed1, 0);
        chk("midrst_m_proceed2", m_proceed2, 0);
        chk("midrst_m_proceed3", m_proceed3, 0);
        rst = 0;
        r0 = rx_cnt;
        repeat (60) @(negedge clk);
        chk("midrst_no_stale", rx_cnt - r0, 0);
        chk("midrst_no_done", done_cnt - d0, 0);
        run_t1();

        stream(150, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
